compare_multi_pipe: RTL and testbench

Parametrised, pipelined magnitude comparator for the waveform generator. It compares LANES independent operand pairs of WIDTH bits each. Six relational modes are selectable, with signed or unsigned interpretation. Per-lane rise and fall events flag threshold crossings between consecutive valid samples. It feeds PWM/duty and threshold-crossing logic, and its fixed-latency valid pipeline replaces the single-lane combinational greater-than compare.

---
 rtl/compare_pkg.sv | 32 +++
 rtl/compare_chunk.sv | 14 +
 rtl/compare_multi_pipe.sv | 166 ++++++++++++++++
 tb/tb_compare_multi_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared types and helpers for the pipelined multi-lane magnitude comparator.
package compare_pkg;

   // Relation select codes; 3'b110 and 3'b111 are reserved and yield 0.
   typedef enum logic [2:0] {
      CMP_GT = 3'b000,
      CMP_GE = 3'b001,
      CMP_LT = 3'b010,
      CMP_LE = 3'b011,
      CMP_EQ = 3'b100,
      CMP_NE = 3'b101
   } cmp_mode_e;

   // Map merged greater/equal flags onto the selected relation.
   function automatic logic apply_mode(input logic gt, input logic eq, input logic [2:0] mode);
      logic lt;
      logic res;
      lt  = ~gt & ~eq;
      res = 1'b0;
      case (mode)
         CMP_GT:  res = gt;
         CMP_GE:  res = gt | eq;
         CMP_LT:  res = lt;
         CMP_LE:  res = lt | eq;
         CMP_EQ:  res = eq;
         CMP_NE:  res = ~eq;
         default: res = 1'b0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/compare_chunk.sv
// Combinational unsigned greater-than / equality on one CHUNK-bit slice.
module compare_chunk #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   output logic             o_gt,
   output logic             o_eq
);

   assign o_gt = (i_a > i_b);
   assign o_eq = (i_a == i_b);

endmodule

// File: rtl/compare_multi_pipe.sv
// Two-stage pipelined LANES-wide magnitude comparator with per-lane
// rise/fall crossing events between consecutive valid samples.
module compare_multi_pipe
   import compare_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 4,
   parameter int CHUNK = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_valid,
   input  logic [LANES*WIDTH-1:0] i_a,
   input  logic [LANES*WIDTH-1:0] i_b,
   input  logic [2:0]             i_mode,
   input  logic                   i_signed,
   input  logic                   i_clear,
   output logic                   o_valid,
   output logic [LANES-1:0]       o_result,
   output logic [LANES-1:0]       o_rise,
   output logic [LANES-1:0]       o_fall
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int NSUB = LANES * NCH;

   // Elaboration-time parameter sanity checks.
   if ((WIDTH % CHUNK) != 0) begin : g_chunk_check
      $error("compare_multi_pipe: WIDTH must be a multiple of CHUNK");
   end
   if (WIDTH < 2) begin : g_width_check
      $error("compare_multi_pipe: WIDTH must be at least 2");
   end
   if (LANES < 1) begin : g_lanes_check
      $error("compare_multi_pipe: LANES must be at least 1");
   end

   // ---------------- stage 0: offset-binary conversion and chunk compares
   logic [LANES*WIDTH-1:0] a_ob;
   logic [LANES*WIDTH-1:0] b_ob;
   logic [NSUB-1:0]        gt_c;
   logic [NSUB-1:0]        eq_c;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   always_comb begin
      a_ob = i_a;
      b_ob = i_b;
      if (i_signed) begin
         for (int n = 0; n < LANES; n++) begin
            a_ob[n*WIDTH + WIDTH - 1] = ~i_a[n*WIDTH + WIDTH - 1];
            b_ob[n*WIDTH + WIDTH - 1] = ~i_b[n*WIDTH + WIDTH - 1];
         end
      end
   end

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      for (genvar k = 0; k < NCH; k++) begin : g_chunk
         compare_chunk #(
            .CHUNK (CHUNK)
         ) u_chunk (
            .i_a  (a_ob[n*WIDTH + k*CHUNK +: CHUNK]),
            .i_b  (b_ob[n*WIDTH + k*CHUNK +: CHUNK]),
            .o_gt (gt_c[n*NCH + k]),
            .o_eq (eq_c[n*NCH + k])
         );
      end
   end

   // ---------------- stage 1 registers
   logic            vld_p1_q,  vld_p1_d;
   logic [2:0]      mode_p1_q, mode_p1_d;
   logic [NSUB-1:0] gt_p1_q,   gt_p1_d;
   logic [NSUB-1:0] eq_p1_q,   eq_p1_d;

   // Next-state for stage 1: capture chunk flags and mode with the qualifier.
   always_comb begin
      vld_p1_d  = i_valid;
      mode_p1_d = i_mode;
      gt_p1_d   = gt_c;
      eq_p1_d   = eq_c;
   end

   // Stage-1 control: only the valid bit is reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p1_q <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
      end
   end

   // Stage-1 data: free-running, qualified by vld_p1_q downstream.
   always_ff @(posedge i_clk) begin
      mode_p1_q <= mode_p1_d;
      gt_p1_q   <= gt_p1_d;
      eq_p1_q   <= eq_p1_d;
   end

   // ---------------- stage 2: chunk merge, mode, edge detection
   logic [LANES-1:0] lane_gt;
   logic [LANES-1:0] lane_eq;
   logic [LANES-1:0] lane_res;

   // Merge chunks MSB-first: a lower chunk only decides if all higher chunks tie.
   always_comb begin
      lane_gt  = '0;
      lane_eq  = '1;
      lane_res = '0;
      for (int n = 0; n < LANES; n++) begin
         for (int k = NCH - 1; k >= 0; k--) begin
            lane_gt[n] = lane_gt[n] | (gt_p1_q[n*NCH + k] & lane_eq[n]);
            lane_eq[n] = lane_eq[n] & eq_p1_q[n*NCH + k];
         end
         lane_res[n] = apply_mode(lane_gt[n], lane_eq[n], mode_p1_q);
      end
   end

   logic             vld_p2_q,  vld_p2_d;
   logic [LANES-1:0] res_p2_q,  res_p2_d;
   logic [LANES-1:0] rise_p2_q, rise_p2_d;
   logic [LANES-1:0] fall_p2_q, fall_p2_d;
   logic             hist_valid_q, hist_valid_d;

   // The held result register doubles as the per-lane previous-sample history,
   // since both update only when a valid sample leaves stage 2.
   always_comb begin
      vld_p2_d     = vld_p1_q;
      res_p2_d     = res_p2_q;
      rise_p2_d    = '0;
      fall_p2_d    = '0;
      hist_valid_d = hist_valid_q;
      if (vld_p1_q) begin
         res_p2_d = lane_res;
         if (hist_valid_q && !i_clear) begin
            rise_p2_d = ~res_p2_q & lane_res;
            fall_p2_d = res_p2_q & ~lane_res;
         end
         hist_valid_d = 1'b1;
      end else if (i_clear) begin
         hist_valid_d = 1'b0;
      end
   end

   // Output stage and history flag; reset wins over everything.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_p2_q     <= 1'b0;
         res_p2_q     <= '0;
         rise_p2_q    <= '0;
         fall_p2_q    <= '0;
         hist_valid_q <= 1'b0;
      end else begin
         vld_p2_q     <= vld_p2_d;
         res_p2_q     <= res_p2_d;
         rise_p2_q    <= rise_p2_d;
         fall_p2_q    <= fall_p2_d;
         hist_valid_q <= hist_valid_d;
      end
   end

   assign o_valid  = vld_p2_q;
   assign o_result = res_p2_q;
   assign o_rise   = rise_p2_q;
   assign o_fall   = fall_p2_q;

endmodule

// File: tb/tb_compare_multi_pipe.sv
// Directed-vector and reference-model bench for compare_multi_pipe.
module tb_compare_multi_pipe;

   localparam int WIDTH = 8;
   localparam int LANES = 4;
   localparam int CHUNK = 4;

   logic                   i_clk = 1'b0;
   logic                   i_rst = 1'b1;
   logic                   i_valid = 1'b0;
   logic [LANES*WIDTH-1:0] i_a = '0;
   logic [LANES*WIDTH-1:0] i_b = '0;
   logic [2:0]             i_mode = 3'b000;
   logic                   i_signed = 1'b0;
   logic                   i_clear = 1'b0;
   logic                   o_valid;
   logic [LANES-1:0]       o_result;
   logic [LANES-1:0]       o_rise;
   logic [LANES-1:0]       o_fall;

   int checks = 0;
   int errors = 0;

   compare_multi_pipe #(
      .WIDTH (WIDTH),
      .LANES (LANES),
      .CHUNK (CHUNK)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .i_a      (i_a),
      .i_b      (i_b),
      .i_mode   (i_mode),
      .i_signed (i_signed),
      .i_clear  (i_clear),
      .o_valid  (o_valid),
      .o_result (o_result),
      .o_rise   (o_rise),
      .o_fall   (o_fall)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  mode;
      logic        sgn;
      logic [3:0]  exp;
   } vec_t;

   vec_t tbl [11];

   // Apply one cycle of inputs; outputs are sampled on the next falling edge.
   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] m, input logic s, input logic clr, input logic rst);
      i_valid  = v;
      i_a      = a;
      i_b      = b;
      i_mode   = m;
      i_signed = s;
      i_clear  = clr;
      i_rst    = rst;
      @(negedge i_clk);
   endtask

   // Crossing sequences: lane0 a=a0 vs b=0x40, lanes 1..3 compare 0 vs 0, mode GE.
   task automatic seq(input logic v, input logic [7:0] a0, input logic clr, input logic rst);
      drive(v, {24'h0, a0}, 32'h0000_0040, 3'b001, 1'b0, clr, rst);
   endtask

   task automatic check_all(input string name, input logic ev, input logic [3:0] er,
                            input logic [3:0] erise, input logic [3:0] efall);
      checks++;
      if ({o_valid, o_result, o_rise, o_fall} !== {ev, er, erise, efall}) begin
         errors++;
         $display("FAIL %s: got v=%b res=%b rise=%b fall=%b, want v=%b res=%b rise=%b fall=%b",
                  name, o_valid, o_result, o_rise, o_fall, ev, er, erise, efall);
      end
   endtask

   task automatic check_res(input string name, input logic [3:0] er);
      checks++;
      if ({o_valid, o_result} !== {1'b1, er}) begin
         errors++;
         $display("FAIL %s: got v=%b res=%b, want v=1 res=%b", name, o_valid, o_result, er);
      end
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
      drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b1);
      i_rst = 1'b0;
   endtask

   // Independent reference relation using native signed/unsigned compares.
   function automatic logic ref_rel(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] m, input logic s);
      logic gt;
      logic eq;
      logic r;
      gt = s ? ($signed(a) > $signed(b)) : (a > b);
      eq = (a == b);
      case (m)
         3'd0:    r = gt;
         3'd1:    r = gt || eq;
         3'd2:    r = !gt && !eq;
         3'd3:    r = !gt;
         3'd4:    r = eq;
         3'd5:    r = !eq;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   initial begin
      logic        pv;
      logic [3:0]  pr;
      logic [3:0]  m_res;
      logic        m_hist;
      logic        cv;
      logic [31:0] ca;
      logic [31:0] cb;
      logic [2:0]  cm;
      logic        cs;
      logic [3:0]  cr;
      logic        ev;
      logic [3:0]  erise;
      logic [3:0]  efall;

      //             a              b              mode    sgn   expected lanes 3..0
      tbl[0]  = '{32'h00_50_A4_A5, 32'h00_4F_A5_A4, 3'b000, 1'b0, 4'b0101};
      tbl[1]  = '{32'h7F_FF_01_80, 32'h7F_00_80_01, 3'b010, 1'b1, 4'b0101};
      tbl[2]  = '{32'h7F_FF_01_80, 32'h7F_00_80_01, 3'b010, 1'b0, 4'b0010};
      tbl[3]  = '{32'hF0_00_7F_7F, 32'h0F_00_7E_7F, 3'b100, 1'b0, 4'b0101};
      tbl[4]  = '{32'hF0_00_7F_7F, 32'h0F_00_7E_7F, 3'b111, 1'b0, 4'b0000};
      tbl[5]  = '{32'hF0_00_7F_7F, 32'h0F_00_7E_7F, 3'b110, 1'b1, 4'b0000};
      tbl[6]  = '{32'h0F_FF_3F_40, 32'h10_FE_40_40, 3'b001, 1'b0, 4'b0101};
      tbl[7]  = '{32'h00_FE_7F_80, 32'hFF_FE_80_7F, 3'b011, 1'b1, 4'b0101};
      tbl[8]  = '{32'hAA_10_55_12, 32'hAA_01_55_13, 3'b101, 1'b0, 4'b0101};
      tbl[9]  = '{32'h80_7F_FF_01, 32'h80_80_01_FF, 3'b000, 1'b1, 4'b0101};
      tbl[10] = '{32'h80_7F_FF_01, 32'h80_80_01_FF, 3'b000, 1'b0, 4'b0010};

      do_reset();
      check_all("reset_state", 1'b0, 4'b0000, 4'b0000, 4'b0000);

      // Back-to-back table stream: sample i is visible after the next drive.
      for (int i = 0; i <= 11; i++) begin
         if (i < 11) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].sgn, 1'b0, 1'b0);
         else        drive(1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0);
         if (i >= 1) check_res($sformatf("tbl%0d", i - 1), tbl[i-1].exp);
      end

      // Threshold crossing with GE against 0x40.
      do_reset();
      seq(1'b1, 8'h3F, 1'b0, 1'b0);
      seq(1'b1, 8'h40, 1'b0, 1'b0);
      check_all("cross_first", 1'b1, 4'b1110, 4'b0000, 4'b0000);
      seq(1'b1, 8'h41, 1'b0, 1'b0);
      check_all("cross_rise", 1'b1, 4'b1111, 4'b0001, 4'b0000);
      seq(1'b1, 8'h3E, 1'b0, 1'b0);
      check_all("cross_hold", 1'b1, 4'b1111, 4'b0000, 4'b0000);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("cross_fall", 1'b1, 4'b1110, 4'b0000, 4'b0001);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("cross_idle", 1'b0, 4'b1110, 4'b0000, 4'b0000);

      // Bubbles: valid 1,0,0,1 with an edge across the gap each time.
      seq(1'b1, 8'h41, 1'b0, 1'b0);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("bub_v1", 1'b1, 4'b1111, 4'b0001, 4'b0000);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("bub_gap1", 1'b0, 4'b1111, 4'b0000, 4'b0000);
      seq(1'b1, 8'h3F, 1'b0, 1'b0);
      check_all("bub_gap2", 1'b0, 4'b1111, 4'b0000, 4'b0000);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("bub_v2", 1'b1, 4'b1110, 4'b0000, 4'b0001);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("bub_after", 1'b0, 4'b1110, 4'b0000, 4'b0000);

      // Clear coincident with a rising result: edge suppressed, history reloaded.
      seq(1'b1, 8'h41, 1'b0, 1'b0);
      seq(1'b0, 8'h00, 1'b1, 1'b0);
      check_all("clr_coinc", 1'b1, 4'b1111, 4'b0000, 4'b0000);
      seq(1'b1, 8'h3F, 1'b0, 1'b0);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("clr_next_fall", 1'b1, 4'b1110, 4'b0000, 4'b0001);

      // Clear on its own drops history: the next change reports no edge.
      seq(1'b0, 8'h00, 1'b1, 1'b0);
      seq(1'b1, 8'h41, 1'b0, 1'b0);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("clr_alone", 1'b1, 4'b1111, 4'b0000, 4'b0000);

      // Reset with two samples in flight.
      seq(1'b1, 8'h3F, 1'b0, 1'b0);
      seq(1'b1, 8'h3F, 1'b0, 1'b1);
      check_all("rst_flush", 1'b0, 4'b0000, 4'b0000, 4'b0000);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("rst_no_valid", 1'b0, 4'b0000, 4'b0000, 4'b0000);
      seq(1'b1, 8'h3F, 1'b0, 1'b0);
      seq(1'b0, 8'h00, 1'b0, 1'b0);
      check_all("rst_first_noedge", 1'b1, 4'b1110, 4'b0000, 4'b0000);

      // Random samples against the reference relation and edge model.
      do_reset();
      pv     = 1'b0;
      pr     = 4'b0000;
      m_res  = 4'b0000;
      m_hist = 1'b0;
      for (int j = 0; j < 10000; j++) begin
         cv = ($urandom_range(0, 3) != 0);
         ca = $urandom;
         cb = $urandom;
         if ($urandom_range(0, 7) == 0) cb = ca;
         cm = 3'($urandom_range(0, 7));
         cs = 1'($urandom_range(0, 1));
         for (int n = 0; n < LANES; n++) begin
            cr[n] = ref_rel(ca[n*8 +: 8], cb[n*8 +: 8], cm, cs);
         end
         drive(cv, ca, cb, cm, cs, 1'b0, 1'b0);
         ev    = pv;
         erise = 4'b0000;
         efall = 4'b0000;
         if (pv) begin
            if (m_hist) begin
               erise = ~m_res & pr;
               efall = m_res & ~pr;
            end
            m_res  = pr;
            m_hist = 1'b1;
         end
         check_all($sformatf("rand%0d", j), ev, m_res, erise, efall);
         pv = cv;
         pr = cr;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
